// File: rtl/temp_sample_scheduler.sv
// temp_sample_scheduler
// Sequences the DS18B20 driver: gates its enable for one conversion window,
// retries on timeout, re-arms on a fixed sample period and republishes each
// good reading as a one-cycle strobe for the BCD converter.
// Optional feature: define TEMP_ALARM_EN to build the over-temperature
// alarm with hysteresis; otherwise alarm is tied low.
//
// state | meaning
// IDLE  | sampling disabled (run=0)
// ARM   | start of a sample period, clears period and attempt counters
// WAIT  | sensor enabled, waiting for a reading or the attempt timeout
// RETRY | one cycle with sensor disabled between attempts
// DONE  | good reading captured, clears the timeout error
// GAP   | idle until the sample period has elapsed
module temp_sample_scheduler #(
    parameter int                CLK_FREQ   = 50_000_000,
    parameter int                SAMPLE_MS  = 1000,
    parameter int                TIMEOUT_MS = 1000,
    parameter int                MAX_RETRY  = 3,
    parameter int                DATA_W     = 21,
    parameter logic [DATA_W-1:0] ALARM_HI   = 21'd30000,
    parameter logic [DATA_W-1:0] ALARM_LO   = 21'd28000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              run,
    output logic              sensor_en,
    input  logic [DATA_W-1:0] sensor_data,
    input  logic              sensor_sign,
    input  logic              sensor_vld,
    output logic [DATA_W-1:0] temp_data,
    output logic              temp_sign,
    output logic              temp_vld,
    output logic              busy,
    output logic              err_timeout,
    output logic [15:0]       sample_cnt,
    output logic              alarm
);

    localparam int MS_CYC     = CLK_FREQ / 1000;
    localparam int PERIOD_CYC = SAMPLE_MS * MS_CYC;
    localparam int TMO_CYC    = TIMEOUT_MS * MS_CYC;
    localparam int PER_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int TMO_W      = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RETRY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    // Parameter sanity, evaluated at elaboration only
    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
        $error("MAX_RETRY must be in 1..15");
    end
    if (ALARM_LO >= ALARM_HI) begin : g_bad_alarm
        $error("ALARM_LO must be below ALARM_HI");
    end

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [PER_W-1:0] period_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [4:0]       attempt;
    logic [4:0]       attempt_nxt;
    logic             retry_ok;
    logic             good_sample;

    assign attempt_nxt = attempt + 5'd1;
    assign retry_ok    = (attempt_nxt <= 5'(MAX_RETRY));
    // A reading only counts while the sensor window is open and sampling is on
    assign good_sample = run && (state == S_WAIT) && sensor_vld;

    // Next-state decode; dropping run overrides every state
    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_ARM;
                S_ARM:   state_nxt = S_WAIT;
                S_WAIT: begin
                    if (sensor_vld) begin
                        state_nxt = S_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_nxt = S_RETRY;
                    end
                end
                S_RETRY: state_nxt = retry_ok ? S_WAIT : S_GAP;
                S_DONE:  state_nxt = S_GAP;
                S_GAP: begin
                    if (period_cnt >= PER_LAST) begin
                        state_nxt = S_ARM;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register plus registered enable/busy aligned with the new state
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            sensor_en <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sensor_en <= (state_nxt == S_WAIT);
            busy      <= (state_nxt != S_IDLE);
        end
    end

    // Period counter: reads 0 in the ARM cycle and k cycles after it, saturating
    // at the last period cycle so an overrun re-arms as soon as GAP is reached
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            period_cnt <= '0;
        end else if (state_nxt == S_ARM) begin
            period_cnt <= '0;
        end else if (state != S_IDLE && period_cnt != PER_LAST) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Per-attempt timeout counter, restarts on every WAIT entry
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_cnt <= '0;
        end else if (state != S_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Attempts already failed within the current sample period
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            attempt <= '0;
        end else if (state == S_ARM) begin
            attempt <= '0;
        end else if (state == S_RETRY) begin
            attempt <= attempt_nxt;
        end
    end

    // Published reading, strobe, sample count and sticky timeout error
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            temp_data   <= '0;
            temp_sign   <= 1'b0;
            temp_vld    <= 1'b0;
            sample_cnt  <= '0;
            err_timeout <= 1'b0;
        end else begin
            temp_vld <= 1'b0;
            if (good_sample) begin
                temp_data  <= sensor_data;
                temp_sign  <= sensor_sign;
                temp_vld   <= 1'b1;
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (run && state == S_DONE) begin
                err_timeout <= 1'b0;
            end
            if (run && state == S_RETRY && !retry_ok) begin
                err_timeout <= 1'b1;
            end
        end
    end

`ifdef TEMP_ALARM_EN
    // Over-temperature flag with hysteresis, updated alongside temp_vld
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            alarm <= 1'b0;
        end else if (good_sample) begin
            if (!sensor_sign && sensor_data >= ALARM_HI) begin
                alarm <= 1'b1;
            end else if (sensor_sign || sensor_data < ALARM_LO) begin
                alarm <= 1'b0;
            end
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Bench for temp_sample_scheduler: timeline model of the sampling schedule
// checked every cycle, plus directed scenarios with literal expectations.
module tb_temp_sample_scheduler;

    localparam int DW = 21;
    localparam int P  = 20;
    localparam int T  = 8;
    localparam int MR = 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          run = 1'b0;
    logic [DW-1:0] sensor_data = '0;
    logic          sensor_sign = 1'b0;
    logic          sensor_vld = 1'b0;
    logic          sensor_en;
    logic [DW-1:0] temp_data;
    logic          temp_sign;
    logic          temp_vld;
    logic          busy;
    logic          err_timeout;
    logic [15:0]   sample_cnt;
    logic          alarm;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int tk = 0;

    always #5 sys_clk = ~sys_clk;

    temp_sample_scheduler #(
        .CLK_FREQ  (1000),
        .SAMPLE_MS (20),
        .TIMEOUT_MS(8),
        .MAX_RETRY (2),
        .DATA_W    (DW),
        .ALARM_HI  (21'd100),
        .ALARM_LO  (21'd80)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .run        (run),
        .sensor_en  (sensor_en),
        .sensor_data(sensor_data),
        .sensor_sign(sensor_sign),
        .sensor_vld (sensor_vld),
        .temp_data  (temp_data),
        .temp_sign  (temp_sign),
        .temp_vld   (temp_vld),
        .busy       (busy),
        .err_timeout(err_timeout),
        .sample_cnt (sample_cnt),
        .alarm      (alarm)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Cycle mc is the cycle being closed at each rising edge. The schedule is
    // kept as absolute cycle numbers: when the period was armed, when the
    // current sensor window opens, and when the next period may start.
    int            mc, arm_at, win_start, fails, next_arm, err_at;
    bit            m_idle, win_on;
    logic          err_val;
    logic          e_en, e_busy, e_vld, e_sign, e_err, e_alarm;
    logic [DW-1:0] e_data;
    logic [15:0]   e_cnt;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mc = 0; m_idle = 1; win_on = 0; next_arm = -1; err_at = -1;
            arm_at = 0; win_start = 0; fails = 0; err_val = 0;
            e_en = 0; e_busy = 0; e_vld = 0; e_sign = 0; e_err = 0; e_alarm = 0;
            e_data = '0; e_cnt = '0;
        end else begin
            e_vld = 0;
            if (!run) begin
                m_idle = 1; win_on = 0; next_arm = -1; err_at = -1;
            end else if (m_idle) begin
                m_idle = 0; arm_at = mc + 1; win_on = 1; win_start = mc + 2; fails = 0; next_arm = -1;
            end else begin
                if (err_at == mc) begin
                    e_err = err_val;
                    err_at = -1;
                end
                if (win_on && mc >= win_start) begin
                    if (sensor_vld) begin
                        e_vld = 1; e_data = sensor_data; e_sign = sensor_sign; e_cnt = e_cnt + 16'd1;
`ifdef TEMP_ALARM_EN
                        if (!sensor_sign && sensor_data >= 100) e_alarm = 1;
                        else if (sensor_sign || sensor_data < 80) e_alarm = 0;
`endif
                        win_on = 0;
                        next_arm = max2(arm_at + P, mc + 3);
                        err_at = mc + 1; err_val = 0;
                    end else if (mc - win_start == T - 1) begin
                        fails++;
                        if (fails <= MR) begin
                            win_start = mc + 2;
                        end else begin
                            win_on = 0;
                            next_arm = max2(arm_at + P, mc + 3);
                            err_at = mc + 1; err_val = 1;
                        end
                    end
                end else if (!win_on && next_arm == mc + 1) begin
                    arm_at = mc + 1; win_on = 1; win_start = mc + 2; fails = 0; next_arm = -1;
                end
            end
            mc++;
            e_en   = win_on && (mc >= win_start);
            e_busy = !m_idle;
        end
    end

    // Compare process, away from the active edge
    always @(negedge sys_clk) begin
        check("m_sensor_en", sensor_en, e_en);
        check("m_busy", busy, e_busy);
        check("m_temp_vld", temp_vld, e_vld);
        check("m_temp_data", temp_data, e_data);
        check("m_temp_sign", temp_sign, e_sign);
        check("m_sample_cnt", sample_cnt, e_cnt);
        check("m_err_timeout", err_timeout, e_err);
        check("m_alarm", alarm, e_alarm);
        if (temp_vld === 1'b1) strobes++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
        tk++;
    endtask

    task automatic wait_en(input logic val, input int budget, output int n);
        n = 0;
        while (sensor_en !== val && n < budget) begin
            tick();
            n++;
        end
        if (sensor_en !== val) begin
            checks++;
            errors++;
            $display("FAIL wait_en: sensor_en=%b expected %b within %0d cycles", sensor_en, val, budget);
        end
    endtask

    task automatic pulse_vld(input logic [DW-1:0] d, input logic s);
        sensor_data = d;
        sensor_sign = s;
        sensor_vld  = 1'b1;
        tick();
        sensor_vld  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rise1, rise2, s0, hi;
        int avals [5] = '{90, 100, 90, 79, 200};
        logic asign [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef TEMP_ALARM_EN
        logic aexp [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        logic aexp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_sensor_en", sensor_en, 0);
        sys_rst = 1'b0;
        tick();

        // 1. basic sample
        run = 1'b1;
        wait_en(1'b1, 10, n);
        check("t1_arm_latency", n, 2);
        rise1 = tk;
        repeat (5) tick();
        pulse_vld(21'd2500, 1'b0);
        check("t1_temp_vld", temp_vld, 1);
        check("t1_temp_data", temp_data, 2500);
        check("t1_sample_cnt", sample_cnt, 1);
        wait_en(1'b1, 40, n);
        rise2 = tk;
        check("t1_period", rise2 - rise1, 20);

        // 2. retry then success
        s0 = strobes;
        wait_en(1'b0, 20, n);
        check("t2_wait_len", n, 8);
        wait_en(1'b1, 5, n);
        check("t2_retry_gap", n, 1);
        tick();
        tick();
        pulse_vld(21'd1234, 1'b1);
        check("t2_temp_vld", temp_vld, 1);
        check("t2_temp_sign", temp_sign, 1);
        tick();
        check("t2_err", err_timeout, 0);
        check("t2_strobes", strobes - s0, 1);

        // 3. retry exhaustion, then recovery
        wait_en(1'b1, 40, n);
        s0 = strobes;
        hi = 0;
        for (int i = 0; i < 28; i++) begin
            if (sensor_en === 1'b1) hi++;
            tick();
        end
        check("t3_en_cycles", hi, 24);
        check("t3_err_set", err_timeout, 1);
        check("t3_strobes", strobes - s0, 0);
        wait_en(1'b1, 5, n);
        check("t3_overrun_rearm", n, 1);
        tick();
        pulse_vld(21'd3000, 1'b0);
        tick();
        check("t3_err_clear", err_timeout, 0);

        // 4. vld in final timeout cycle; vld during GAP
        wait_en(1'b1, 40, n);
        repeat (7) tick();
        pulse_vld(21'd555, 1'b0);
        check("t4_last_cycle_vld", temp_vld, 1);
        check("t4_last_cycle_data", temp_data, 555);
        tick();
        check("t4_no_retry", sensor_en, 0);
        tick();
        tick();
        pulse_vld(21'd777, 1'b1);
        check("t4_gap_no_strobe", temp_vld, 0);
        check("t4_gap_data_hold", temp_data, 555);

        // 5. run dropped mid-WAIT, then async reset mid-WAIT
        wait_en(1'b1, 40, n);
        tick();
        tick();
        run = 1'b0;
        sensor_data = 21'd999;
        sensor_vld = 1'b1;
        tick();
        sensor_vld = 1'b0;
        check("t5_run_en", sensor_en, 0);
        check("t5_run_busy", busy, 0);
        check("t5_run_no_strobe", temp_vld, 0);
        check("t5_run_data_hold", temp_data, 555);
        repeat (3) tick();
        run = 1'b1;
        wait_en(1'b1, 10, n);
        check("t5_fresh_arm", n, 2);
        tick();
        tick();
        #2;
        sys_rst = 1'b1;
        #1;
        check("t5_rst_en", sensor_en, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_data", temp_data, 0);
        check("t5_rst_cnt", sample_cnt, 0);
        tick();
        sys_rst = 1'b0;
        tick();

        // 6. alarm hysteresis
        for (int i = 0; i < 5; i++) begin
            wait_en(1'b1, 40, n);
            tick();
            pulse_vld(DW'(avals[i]), asign[i]);
            check($sformatf("t6_alarm_%0d", i), alarm, aexp[i]);
        end
        check("t6_sample_cnt", sample_cnt, 5);

        run = 1'b0;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
